alu_op_sequencer: RTL and testbench

- Instruction-level front end that sits directly upstream of the 6502 ALU.
- Accepts one architectural operation per request (ADC, SBC, ASL, ROL, CMP, BIT, ...) and maps it onto primitive ALU passes (SUM/AND/OR/XOR/SR), sequencing up to two passes.
- Merges ALU outputs into final result and status (C, Z, V, N) and adds the BCD correction pass for decimal mode.
- The control unit issues requests; the register file consumes responses.

---
 rtl/alu_op_sequencer_pkg.sv | 56 +++++
 rtl/alu_op_sequencer_bcd_correct.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the 6502 ALU operation sequencer.
package alu_op_sequencer_pkg;

    localparam int REG_WIDTH = 8;
    localparam int OPP_WIDTH = 3;

    typedef enum logic [OPP_WIDTH-1:0] {
        FUNC_SUM  = 3'd0,
        FUNC_AND  = 3'd1,
        FUNC_OR   = 3'd2,
        FUNC_XOR  = 3'd3,
        FUNC_SR   = 3'd4,
        FUNC_IDLE = 3'd7
    } alu_func_e;

    // Bit positions inside the P register
    typedef enum int {
        CARRY      = 0,
        ZERO       = 1,
        INT_DIS    = 2,
        DEC        = 3,
        BREAK      = 4,
        V_OVERFLOW = 6,
        NEG        = 7
    } status_bit_e;

    typedef enum logic [3:0] {
        OP_ADC = 4'h0,
        OP_SBC = 4'h1,
        OP_AND = 4'h2,
        OP_ORA = 4'h3,
        OP_EOR = 4'h4,
        OP_ASL = 4'h5,
        OP_LSR = 4'h6,
        OP_ROL = 4'h7,
        OP_ROR = 4'h8,
        OP_CMP = 4'h9,
        OP_INC = 4'hA,
        OP_DEC = 4'hB,
        OP_BIT = 4'hC
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE1,
        S_WAIT1,
        S_ISSUE2,
        S_WAIT2,
        S_DONE
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= 4'hC;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_bcd_correct.sv
// Decimal-mode correction for ADC/SBC: derives the pass-2 addend and the
// decimal carry from the operands and the binary pass-1 result.
module alu_op_sequencer_bcd_correct
    import alu_op_sequencer_pkg::*;
#(
    parameter int W = REG_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic [W-1:0] bin,
    input  logic         carry,
    input  logic         is_sbc,
    output logic [W-1:0] corr,
    output logic         dec_carry
);

    logic [4:0] lo_sum;
    logic       lo_adj;
    logic       lo_borrow;
    logic [W:0] adj_sum;

    always_comb begin
        lo_sum    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
        lo_adj    = lo_sum > 5'd9;
        adj_sum   = {carry, bin} + (lo_adj ? (W+1)'(6) : '0);
        dec_carry = adj_sum > (W+1)'(8'h99);
        lo_borrow = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'b0, !cin});
        corr      = '0;
        if (is_sbc) begin
            case ({lo_borrow, !carry})
                2'b10:   corr = W'(8'hFA);
                2'b01:   corr = W'(8'hA0);
                2'b11:   corr = W'(8'h9A);
                default: corr = '0;
            endcase
        end else begin
            corr = (dec_carry ? W'(8'h60) : '0) | (lo_adj ? W'(8'h06) : '0);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Maps architectural 6502 operations onto one or two primitive ALU passes
// and merges the ALU output into the final result and P flags.
//
// state    | meaning
// S_IDLE   | ready; latch request on req_valid
// S_ISSUE1 | ALU func idle so wout drops; pass-1 operands driven
// S_WAIT1  | pass-1 func driven; capture result on first wout
// S_ISSUE2 | ALU func idle; decimal correction operands driven
// S_WAIT2  | correction SUM driven; wait for wout
// S_DONE   | rsp_valid pulse
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int REG_W   = REG_WIDTH
) (
    input  logic                 phi1,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [REG_W-1:0]     req_a,
    input  logic [REG_W-1:0]     req_b,
    input  logic [REG_W-1:0]     status_in,
    output logic [REG_W-1:0]     alu_a,
    output logic [REG_W-1:0]     alu_b,
    output logic [OPP_WIDTH-1:0] alu_func,
    output logic                 alu_carry_in,
    input  logic [REG_W-1:0]     alu_dout,
    input  logic [REG_W-1:0]     alu_status,
    input  logic                 alu_wout,
    output logic                 rsp_valid,
    output logic [REG_W-1:0]     rsp_result,
    output logic [REG_W-1:0]     rsp_status,
    output logic                 rsp_we,
    output logic                 rsp_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int MSB   = REG_W - 1;

    state_e           state_q, state_d;
    logic [3:0]       op_q;
    logic [REG_W-1:0] a_q, b_q, p_q, r1_q;
    logic             c1_q;
    logic [CNT_W-1:0] cnt_q;

    alu_func_e        p1_func;
    logic [REG_W-1:0] p1_b;
    logic             p1_cin;
    logic             decimal;
    logic [REG_W-1:0] corr;
    logic             dec_carry;
    logic             in_wait;

    logic [REG_W-1:0] r1_eff;
    logic             c1_eff;
    logic [REG_W-1:0] fin_result, fin_status;
    logic             fin_we, fin_err;

    logic             unused_status;
    assign unused_status = ^alu_status[REG_W-1:1];

    assign decimal = p_q[DEC] && (op_q == OP_ADC || op_q == OP_SBC);
    assign in_wait = (state_q == S_WAIT1) || (state_q == S_WAIT2);

    alu_op_sequencer_bcd_correct #(.W(REG_W)) u_bcd (
        .a         (a_q),
        .b         (b_q),
        .cin       (p_q[CARRY]),
        .bin       (r1_q),
        .carry     (c1_q),
        .is_sbc    (op_q == OP_SBC),
        .corr      (corr),
        .dec_carry (dec_carry)
    );

    always_comb begin
        p1_func = FUNC_SUM;
        p1_b    = b_q;
        p1_cin  = 1'b0;
        case (op_q)
            OP_ADC:         p1_cin = p_q[CARRY];
            OP_SBC: begin
                p1_b   = ~b_q;
                p1_cin = p_q[CARRY];
            end
            OP_CMP: begin
                p1_b   = ~b_q;
                p1_cin = 1'b1;
            end
            OP_AND, OP_BIT: p1_func = FUNC_AND;
            OP_ORA:         p1_func = FUNC_OR;
            OP_EOR:         p1_func = FUNC_XOR;
            OP_ASL:         p1_b = a_q;
            OP_ROL: begin
                p1_b   = a_q;
                p1_cin = p_q[CARRY];
            end
            OP_LSR, OP_ROR: begin
                p1_func = FUNC_SR;
                p1_b    = '0;
            end
            OP_INC: begin
                p1_b   = '0;
                p1_cin = 1'b1;
            end
            OP_DEC:         p1_b = '1;
            default: ;
        endcase
    end

    always_ff @(posedge phi1) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_carry_in = 1'b0;
        alu_func     = FUNC_IDLE;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = op_is_legal(req_op) ? S_ISSUE1 : S_DONE;
            end
            S_ISSUE1: begin
                alu_a        = a_q;
                alu_b        = p1_b;
                alu_carry_in = p1_cin;
                state_d      = S_WAIT1;
            end
            S_WAIT1: begin
                alu_a        = a_q;
                alu_b        = p1_b;
                alu_carry_in = p1_cin;
                alu_func     = p1_func;
                if (alu_wout)           state_d = decimal ? S_ISSUE2 : S_DONE;
                else if (cnt_q == '0)   state_d = S_DONE;
            end
            S_ISSUE2: begin
                alu_a   = r1_q;
                alu_b   = corr;
                state_d = S_WAIT2;
            end
            S_WAIT2: begin
                alu_a    = r1_q;
                alu_b    = corr;
                alu_func = FUNC_SUM;
                if (alu_wout || cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Final merge is evaluated on the cycle that leads into DONE; in WAIT1
    // the pass-1 result is still on the ALU bus rather than in r1_q.
    always_comb begin
        r1_eff     = (state_q == S_WAIT1) ? alu_dout : r1_q;
        c1_eff     = (state_q == S_WAIT1) ? alu_status[CARRY] : c1_q;
        fin_result = '0;
        fin_status = p_q;
        fin_we     = 1'b0;
        fin_err    = 1'b1;
        if (state_q == S_IDLE) begin
            fin_status = status_in;
        end else if (alu_wout) begin
            fin_err    = 1'b0;
            fin_we     = 1'b1;
            fin_result = r1_eff;
            case (op_q)
                OP_ADC, OP_SBC: begin
                    fin_status[CARRY]      = c1_eff;
                    fin_status[V_OVERFLOW] = (a_q[MSB] == p1_b[MSB]) && (r1_eff[MSB] != a_q[MSB]);
                    fin_status[NEG]        = r1_eff[MSB];
                    fin_status[ZERO]       = (r1_eff == '0);
                    if (decimal) begin
                        fin_result = alu_dout;
                        if (op_q == OP_ADC) fin_status[CARRY] = dec_carry;
                    end
                end
                OP_CMP: begin
                    fin_we            = 1'b0;
                    fin_status[CARRY] = c1_eff;
                    fin_status[NEG]   = r1_eff[MSB];
                    fin_status[ZERO]  = (r1_eff == '0);
                end
                OP_BIT: begin
                    fin_we                 = 1'b0;
                    fin_status[ZERO]       = (r1_eff == '0);
                    fin_status[NEG]        = b_q[MSB];
                    fin_status[V_OVERFLOW] = b_q[MSB-1];
                end
                default: begin
                    if (op_q == OP_ROR) fin_result[MSB] = r1_eff[MSB] | p_q[CARRY];
                    if (op_q == OP_ASL || op_q == OP_ROL) fin_status[CARRY] = a_q[MSB];
                    if (op_q == OP_LSR || op_q == OP_ROR) fin_status[CARRY] = a_q[0];
                    fin_status[NEG]  = fin_result[MSB];
                    fin_status[ZERO] = (fin_result == '0);
                end
            endcase
        end
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            r1_q       <= '0;
            c1_q       <= 1'b0;
            cnt_q      <= '0;
            rsp_result <= '0;
            rsp_status <= '0;
            rsp_we     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
                p_q  <= status_in;
            end
            if (state_q == S_ISSUE1 || state_q == S_ISSUE2)
                cnt_q <= CNT_W'(TIMEOUT - 1);
            else if (in_wait && !alu_wout && cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
            if (state_q == S_WAIT1 && alu_wout) begin
                r1_q <= alu_dout;
                c1_q <= alu_status[CARRY];
            end
            if (state_d == S_DONE) begin
                rsp_result <= fin_result;
                rsp_status <= fin_status;
                rsp_we     <= fin_we;
                rsp_err    <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered ALU stand-in and a
// response scoreboard.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic       phi1 = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = '0;
    logic [7:0] req_a = '0, req_b = '0, status_in = '0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_func;
    logic       alu_carry_in;
    logic [7:0] alu_dout = '0, alu_status = '0;
    logic       alu_wout = 1'b0;
    logic       alu_stall = 1'b0;
    logic       rsp_valid, rsp_we, rsp_err;
    logic [7:0] rsp_result, rsp_status;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] res;
        logic [7:0] st;
        logic       we;
        logic       err;
        logic       chk_res;
        int         lat;
        int         acc;
    } exp_t;
    exp_t sb[$];

    alu_op_sequencer #(.TIMEOUT(8), .REG_W(8)) dut (
        .phi1(phi1), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .status_in(status_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_carry_in(alu_carry_in),
        .alu_dout(alu_dout), .alu_status(alu_status), .alu_wout(alu_wout),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_status(rsp_status),
        .rsp_we(rsp_we), .rsp_err(rsp_err)
    );

    always #5 phi1 = ~phi1;
    always @(posedge phi1) cyc <= cyc + 1;

    // Registered ALU stand-in; upper status bits set to catch misuse.
    logic [8:0] alu_sum;
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_carry_in};
    always @(posedge phi1) begin
        if (alu_func == FUNC_IDLE || alu_stall) begin
            alu_wout <= 1'b0;
        end else begin
            alu_wout <= 1'b1;
            case (alu_func)
                FUNC_SUM: begin alu_dout <= alu_sum[7:0];        alu_status <= {7'h7F, alu_sum[8]}; end
                FUNC_AND: begin alu_dout <= alu_a & alu_b;       alu_status <= 8'hFE; end
                FUNC_OR:  begin alu_dout <= alu_a | alu_b;       alu_status <= 8'hFE; end
                FUNC_XOR: begin alu_dout <= alu_a ^ alu_b;       alu_status <= 8'hFE; end
                FUNC_SR:  begin alu_dout <= {1'b0, alu_a[7:1]}; alu_status <= {7'h7F, alu_a[0]}; end
                default:  begin alu_dout <= 8'h00;               alu_status <= 8'h00; end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge phi1) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_res) chk("rsp_result", 32'(rsp_result), 32'(e.res));
                chk("rsp_status", 32'(rsp_status), 32'(e.st));
                chk("rsp_we", 32'(rsp_we), 32'(e.we));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] p, input logic [7:0] er, input logic [7:0] es,
                         input logic ew, input logic ee, input logic cr, input int lat,
                         input int hold);
        exp_t e;
        @(negedge phi1);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_op = op; req_a = a; req_b = b; status_in = p; req_valid = 1'b1;
        e.res = er; e.st = es; e.we = ew; e.err = ee; e.chk_res = cr; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        @(posedge phi1); #1;
        req_op = 4'hE; req_a = ~a; req_b = ~b; status_in = ~p;
        repeat (hold) begin @(posedge phi1); #1; end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge phi1);
            n++;
        end
        chk("response_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        repeat (3) @(posedge phi1);
        @(negedge phi1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_func", 32'(alu_func), 32'(FUNC_IDLE));
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        reset = 1'b0;

        //    op      a      b      P      res    P_out  we    err   chkres lat hold
        issue(OP_ADC, 8'h50, 8'h50, 8'h00, 8'hA0, 8'hC0, 1'b1, 1'b0, 1'b1, 4, 2); drain();
        issue(OP_SBC, 8'h00, 8'h01, 8'h01, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_CMP, 8'h10, 8'h10, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 4, 0); drain();
        issue(OP_ADC, 8'h19, 8'h28, 8'h08, 8'h47, 8'h08, 1'b1, 1'b0, 1'b1, 7, 0); drain();
        issue(OP_ADC, 8'h99, 8'h01, 8'h08, 8'h00, 8'h89, 1'b1, 1'b0, 1'b1, 7, 0); drain();
        issue(OP_SBC, 8'h42, 8'h13, 8'h09, 8'h29, 8'h09, 1'b1, 1'b0, 1'b1, 7, 0); drain();
        issue(OP_ROR, 8'h01, 8'h00, 8'h01, 8'h80, 8'h81, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_BIT, 8'h0F, 8'hC0, 8'h00, 8'h00, 8'hC2, 1'b0, 1'b0, 1'b0, 4, 0); drain();
        issue(OP_ASL, 8'h81, 8'h00, 8'h00, 8'h02, 8'h01, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_ROL, 8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_LSR, 8'h01, 8'h00, 8'h80, 8'h00, 8'h03, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_INC, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_DEC, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_AND, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_ORA, 8'h80, 8'h01, 8'h00, 8'h81, 8'h80, 1'b1, 1'b0, 1'b1, 4, 0); drain();
        issue(OP_EOR, 8'hF0, 8'hFF, 8'h00, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1, 4, 0); drain();

        alu_stall = 1'b1;
        issue(OP_ADC, 8'h11, 8'h22, 8'h25, 8'h00, 8'h25, 1'b0, 1'b1, 1'b0, 10, 0); drain();
        alu_stall = 1'b0;
        issue(4'hE,   8'h11, 8'h22, 8'h42, 8'h00, 8'h42, 1'b0, 1'b1, 1'b0, 1, 0); drain();

        // Abort a decimal ADC while it sits in WAIT2.
        issue(OP_ADC, 8'h19, 8'h28, 8'h08, 8'h47, 8'h08, 1'b1, 1'b0, 1'b1, 7, 0);
        repeat (4) @(posedge phi1);
        @(negedge phi1);
        chk("wait2_func", 32'(alu_func), 32'(FUNC_SUM));
        reset = 1'b1;
        sb.delete();
        @(negedge phi1);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_func", 32'(alu_func), 32'(FUNC_IDLE));
        chk("abort_alu_b", 32'(alu_b), 32'd0);
        chk("abort_result", 32'(rsp_result), 32'd0);
        chk("abort_we", 32'(rsp_we), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge phi1);
        issue(OP_ADC, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1, 4, 0); drain();

        repeat (3) @(negedge phi1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
